// File: rtl/alu_pkg.sv
// Shared ALU function-select codes, flag bit positions and the multiply sequencer state encoding.
package alu_pkg;

  localparam logic [4:0] FS_A16   = 5'b00000;
  localparam logic [4:0] FS_B16   = 5'b00001;
  localparam logic [4:0] FS_SUB16 = 5'b00110;
  localparam logic [4:0] FS_A32   = 5'b10000;
  localparam logic [4:0] FS_B32   = 5'b10001;
  localparam logic [4:0] FS_ADD32 = 5'b10100;
  localparam logic [4:0] FS_SUB32 = 5'b10110;
  localparam logic [4:0] FS_LSL32 = 5'b11011;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_ADD,
    S_SHIFT,
    S_NEG_P,
    S_FLAGS,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_multiply_sequencer.sv
// Shift/add 16x16->32 multiplier that borrows the external ALU for every arithmetic step;
// signed operands are reduced to magnitudes first and the sign is reapplied at the end.
module alu_multiply_sequencer
  import alu_pkg::*;
#(
  parameter int OP_W = 16,
  parameter int ITER = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Signed,
  input  logic [OP_W-1:0] OpA,
  input  logic [OP_W-1:0] OpB,
  output logic [31:0]     AluA,
  output logic [31:0]     AluB,
  output logic [4:0]      AluFunSel,
  output logic            AluWF,
  input  logic [31:0]     AluOut,
  input  logic [3:0]      AluFlags,
  output logic [31:0]     Product,
  output logic            ResZero,
  output logic            ResNeg,
  output logic            Busy,
  output logic            Done
);

  state_t          r_state;
  logic [31:0]     r_m;
  logic [31:0]     r_p;
  logic [OP_W-1:0] r_q;
  logic [4:0]      r_cnt;
  logic            r_sgn;
  logic            r_signed;
  logic [OP_W-1:0] r_opa;
  logic [OP_W-1:0] r_opb;

  logic w_unused_flags;

  // Carry and overflow are never consumed: unsigned products cannot exceed 32 bits.
  assign w_unused_flags = AluFlags[FLAG_C] ^ AluFlags[FLAG_V];
  assign Busy = (r_state != S_IDLE);

  always_comb begin
    AluA      = '0;
    AluB      = '0;
    AluFunSel = FS_A32;
    AluWF     = 1'b0;
    case (r_state)
      S_NEG_A: begin
        AluB      = {{(32-OP_W){1'b0}}, r_opa};
        AluFunSel = (r_signed && r_opa[OP_W-1]) ? FS_SUB16 : FS_B16;
      end
      S_NEG_B: begin
        AluB      = {{(32-OP_W){1'b0}}, r_opb};
        AluFunSel = (r_signed && r_opb[OP_W-1]) ? FS_SUB16 : FS_B16;
      end
      S_ADD: begin
        AluA = r_p;
        if (r_q[0]) begin
          AluB      = r_m;
          AluFunSel = FS_ADD32;
        end
      end
      S_SHIFT: begin
        AluA      = r_m;
        AluFunSel = FS_LSL32;
      end
      S_NEG_P: begin
        AluB      = r_p;
        AluFunSel = r_sgn ? FS_SUB32 : FS_B32;
      end
      S_FLAGS: begin
        AluA  = r_p;
        AluWF = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_m      <= '0;
      r_p      <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_sgn    <= 1'b0;
      r_signed <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      Product  <= '0;
      ResZero  <= 1'b0;
      ResNeg   <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_opa    <= OpA;
            r_opb    <= OpB;
            r_signed <= Signed;
            r_sgn    <= Signed & (OpA[OP_W-1] ^ OpB[OP_W-1]);
            r_p      <= '0;
            r_cnt    <= '0;
            r_state  <= S_NEG_A;
          end
        end
        S_NEG_A: begin
          r_m     <= AluOut;
          r_state <= S_NEG_B;
        end
        S_NEG_B: begin
          r_q     <= AluOut[OP_W-1:0];
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_p     <= AluOut;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_m     <= AluOut;
          r_q     <= r_q >> 1;
          r_cnt   <= r_cnt + 5'd1;
          r_state <= (r_cnt == 5'(ITER-1)) ? S_NEG_P : S_ADD;
        end
        S_NEG_P: begin
          r_p     <= AluOut;
          r_state <= S_FLAGS;
        end
        S_FLAGS: r_state <= S_DONE;
        // The ALU flag register was written on the FLAGS edge, so it is readable here.
        S_DONE: begin
          Product <= r_p;
          ResZero <= AluFlags[FLAG_Z];
          ResNeg  <= AluFlags[FLAG_N];
          Done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
